// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, flag bit positions, instruction fields
// and the issue-stage state encoding.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_LDI = 4'd8;
   localparam logic [3:0] OP_LUI = 4'd9;
   localparam logic [3:0] OP_NOT = 4'd15;

   localparam int FLG_C = 3;
   localparam int FLG_N = 2;
   localparam int FLG_V = 1;
   localparam int FLG_Z = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_WB   = 2'b10
   } issue_state_e;

   function automatic logic [3:0] instr_op(input logic [15:0] ins);
      return ins[15:12];
   endfunction

   function automatic logic [2:0] instr_rd(input logic [15:0] ins);
      return ins[11:9];
   endfunction

   function automatic logic [2:0] instr_rs1(input logic [15:0] ins);
      return ins[8:6];
   endfunction

   function automatic logic [2:0] instr_rs2(input logic [15:0] ins);
      return ins[5:3];
   endfunction

   function automatic logic [7:0] instr_imm8(input logic [15:0] ins);
      return ins[7:0];
   endfunction

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op inside {[4'd1:4'd7]}) || (op == OP_NOT);
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op inside {[4'd10:4'd14]};
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x16 register file: one synchronous write port, two combinational operand
// read ports and a combinational debug read port; async active-low clear.
module regfile8x16 #(
   parameter int NREGS = 8,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we_i,
   input  logic [$clog2(NREGS)-1:0] waddr_i,
   input  logic [DW-1:0]            wdata_i,
   input  logic [$clog2(NREGS)-1:0] ra1_i,
   output logic [DW-1:0]            rd1_o,
   input  logic [$clog2(NREGS)-1:0] ra2_i,
   output logic [DW-1:0]            rd2_o,
   input  logic [$clog2(NREGS)-1:0] dbg_addr_i,
   output logic [DW-1:0]            dbg_data_o
);

   logic [NREGS-1:0][DW-1:0] regs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= '0;
      else if (we_i) regs_q[waddr_i] <= wdata_i;
   end

   assign rd1_o      = regs_q[ra1_i];
   assign rd2_o      = regs_q[ra2_i];
   assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage: decodes instructions, feeds operands to the
// registered ALU and writes its result and flags back two cycles later.
module alu_issue
   import cpu_pkg::*;
#(
   parameter int NREGS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic [3:0]  alu_op,
   output logic [15:0] oper_a,
   output logic [15:0] oper_b,
   input  logic [15:0] alu_out,
   input  logic [3:0]  alu_flags,
   output logic [3:0]  flags,
   output logic        illegal,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   issue_state_e state_q, state_d;
   logic [3:0]   alu_op_q, alu_op_d;
   logic [15:0]  oper_a_q, oper_a_d;
   logic [15:0]  oper_b_q, oper_b_d;
   logic [2:0]   wb_rd_q, wb_rd_d;
   logic [3:0]   flags_q, flags_d;
   logic         illegal_q, illegal_d;

   logic [3:0]   op;
   logic [2:0]   rd, rs1, rs2;
   logic [7:0]   imm8;
   logic         accept;
   logic [2:0]   ra1;
   logic [15:0]  rd1, rd2;
   logic         we;
   logic [2:0]   waddr;
   logic [15:0]  wdata;

   assign op          = instr_op(instr);
   assign rd          = instr_rd(instr);
   assign rs1         = instr_rs1(instr);
   assign rs2         = instr_rs2(instr);
   assign imm8        = instr_imm8(instr);
   assign instr_ready = (state_q == ST_IDLE);
   assign accept      = instr_valid & instr_ready;

   // LUI must keep the low byte of R[rd], so port 1 reads rd for it.
   assign ra1 = (op == OP_LUI) ? rd : rs1;

   regfile8x16 #(.NREGS(NREGS), .DW(16)) u_rf (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (we),
      .waddr_i    (waddr),
      .wdata_i    (wdata),
      .ra1_i      (ra1),
      .rd1_o      (rd1),
      .ra2_i      (rs2),
      .rd2_o      (rd2),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

   always_comb begin
      state_d   = state_q;
      alu_op_d  = alu_op_q;
      oper_a_d  = oper_a_q;
      oper_b_d  = oper_b_q;
      wb_rd_d   = wb_rd_q;
      flags_d   = flags_q;
      illegal_d = 1'b0;
      we        = 1'b0;
      waddr     = rd;
      wdata     = 16'h0000;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_alu_op(op)) begin
                  state_d  = ST_EXEC;
                  alu_op_d = op;
                  oper_a_d = rd1;
                  oper_b_d = rd2;
                  wb_rd_d  = rd;
               end else if (op == OP_LDI) begin
                  we    = 1'b1;
                  wdata = {8'h00, imm8};
               end else if (op == OP_LUI) begin
                  we    = 1'b1;
                  wdata = {imm8, rd1[7:0]};
               end else begin
                  illegal_d = is_illegal(op);
               end
            end
         end
         // ALU registers its result at the end of EXEC; it sees opcode 0 in WB.
         ST_EXEC: begin
            state_d  = ST_WB;
            alu_op_d = 4'h0;
            oper_a_d = 16'h0000;
            oper_b_d = 16'h0000;
         end
         ST_WB: begin
            state_d = ST_IDLE;
            we      = 1'b1;
            waddr   = wb_rd_q;
            wdata   = alu_out;
            flags_d = alu_flags;
         end
         default: begin
            state_d  = ST_IDLE;
            alu_op_d = 4'h0;
            oper_a_d = 16'h0000;
            oper_b_d = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         alu_op_q  <= 4'h0;
         oper_a_q  <= 16'h0000;
         oper_b_q  <= 16'h0000;
         wb_rd_q   <= 3'd0;
         flags_q   <= 4'h0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_op_q  <= alu_op_d;
         oper_a_q  <= oper_a_d;
         oper_b_q  <= oper_b_d;
         wb_rd_q   <= wb_rd_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
      end
   end

   assign alu_op  = alu_op_q;
   assign oper_a  = oper_a_q;
   assign oper_b  = oper_b_q;
   assign flags   = flags_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a registered reference ALU closes the loop and a
// scoreboard of expected write-backs is checked as each ALU op retires.
module tb_alu_issue;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = 16'h0000;
   logic [3:0]  alu_op;
   logic [15:0] oper_a, oper_b;
   logic [15:0] alu_out;
   logic [3:0]  alu_flags;
   logic [3:0]  flags;
   logic        illegal;
   logic [2:0]  dbg_addr = 3'd0;
   logic [15:0] dbg_data;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [2:0]  rd;
      logic [15:0] val;
      logic [3:0]  flg;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] mreg[8];
   logic [3:0]  mflags;

   always #5 clk = ~clk;

   alu_issue #(.NREGS(8)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_op(alu_op), .oper_a(oper_a), .oper_b(oper_b),
      .alu_out(alu_out), .alu_flags(alu_flags), .flags(flags), .illegal(illegal),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Reference ALU: {C,N,V,Z, result}; SUB computes B - A.
   function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic        c, v;
      s = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         OP_SUB: begin
            r = b - a; c = (b < a);
            v = (a[15] != b[15]) && (r[15] != b[15]);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SHL: r = a << b[3:0];
         OP_SHR: r = a >> b[3:0];
         OP_NOT: r = ~a;
         default: r = '0;
      endcase
      return {c, r[15], v, (r == 16'h0000), r};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {alu_flags, alu_out} <= '0;
      else        {alu_flags, alu_out} <= alu_f(alu_op, oper_a, oper_b);
   end

   function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
      return {op, d, s1, s2, 3'b000};
   endfunction

   function automatic logic [15:0] li(input logic [3:0] op, input logic [2:0] d, input logic [7:0] imm);
      return {op, d, 1'b0, imm};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
      mflags = 4'h0;
      sb_q.delete();
   endtask

   // Drive one instruction through the handshake; returns just after the accept edge.
   task automatic send(input logic [15:0] ins);
      int          n;
      logic [3:0]  op;
      logic [2:0]  d;
      logic [19:0] r;
      exp_t        e;
      n = 0;
      instr = ins; instr_valid = 1'b1;
      while (!instr_ready && n < 20) begin tick(); n++; end
      n_chk++;
      if (n >= 20) begin n_fail++; $display("FAIL send_timeout: instr_ready=%b after %0d cycles, required 1", instr_ready, n); end
      tick();
      instr_valid = 1'b0; instr = 16'($urandom);
      op = ins[15:12]; d = ins[11:9];
      if (op == OP_LDI) mreg[d] = {8'h00, ins[7:0]};
      else if (op == OP_LUI) mreg[d][15:8] = ins[7:0];
      else if (is_alu_op(op)) begin
         r = alu_f(op, mreg[ins[8:6]], mreg[ins[5:3]]);
         e.rd = d; e.val = r[15:0]; e.flg = r[19:16];
         sb_q.push_back(e);
         mreg[d] = r[15:0]; mflags = r[19:16];
      end
   endtask

   // Scoreboard consumer: wait for the stage to return to IDLE, then compare.
   task automatic retire(input int pre);
      int   lo;
      exp_t e;
      lo = pre;
      while (!instr_ready && lo < 10) begin tick(); lo++; end
      n_chk++;
      if (lo != 2) begin n_fail++; $display("FAIL ready_low_cycles: got %0d, required 2", lo); end
      e = sb_q.pop_front();
      dbg_addr = e.rd; #1;
      n_chk++;
      if (dbg_data !== e.val) begin n_fail++; $display("FAIL wb_value r%0d: got %h, required %h", e.rd, dbg_data, e.val); end
      n_chk++;
      if (flags !== e.flg) begin n_fail++; $display("FAIL wb_flags: got %b, required %b", flags, e.flg); end
   endtask

   task automatic test_reset();
      send(rr(OP_ADD, 3'd2, 3'd0, 3'd0));
      retire(0);
      send(li(OP_LDI, 3'd1, 8'h55));
      send(16'hB000);
      rst_n = 1'b0; #1;
      model_reset();
      n_chk++;
      if ({alu_op, oper_a, oper_b, flags, illegal} !== 41'h0) begin
         n_fail++; $display("FAIL reset_outputs: op=%h a=%h b=%h flags=%b illegal=%b, required all 0", alu_op, oper_a, oper_b, flags, illegal);
      end
      tick(); rst_n = 1'b1; tick();
      n_chk++;
      if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", instr_ready); end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         n_chk++;
         if (dbg_data !== 16'h0000) begin n_fail++; $display("FAIL reset_reg r%0d: got %h, required 0000", i, dbg_data); end
      end
   endtask

   task automatic test_add();
      send(li(OP_LDI, 3'd1, 8'h05));
      dbg_addr = 3'd1; #1;
      n_chk++;
      if (dbg_data !== 16'h0005) begin n_fail++; $display("FAIL ldi_visible: got %h, required 0005", dbg_data); end
      send(li(OP_LDI, 3'd2, 8'h03));
      send(rr(OP_ADD, 3'd3, 3'd1, 3'd2));
      n_chk++;
      if (alu_op !== OP_ADD || oper_a !== 16'h0005 || oper_b !== 16'h0003) begin
         n_fail++; $display("FAIL add_exec: op=%h a=%h b=%h, required 1/0005/0003", alu_op, oper_a, oper_b);
      end
      retire(0);
      dbg_addr = 3'd3; #1;
      n_chk++;
      if (dbg_data !== 16'h0008 || flags !== 4'b0000) begin
         n_fail++; $display("FAIL add_result: r3=%h flags=%b, required 0008/0000", dbg_data, flags);
      end
   endtask

   task automatic test_sub();
      send(rr(OP_SUB, 3'd4, 3'd1, 3'd2));
      n_chk++;
      if (oper_a !== 16'h0005 || oper_b !== 16'h0003) begin
         n_fail++; $display("FAIL sub_exec: a=%h b=%h, required 0005/0003", oper_a, oper_b);
      end
      tick();
      n_chk++;
      if ({alu_op, oper_a, oper_b} !== 36'h0 || instr_ready !== 1'b0) begin
         n_fail++; $display("FAIL wb_outputs: op=%h a=%h b=%h ready=%b, required 0/0/0/0", alu_op, oper_a, oper_b, instr_ready);
      end
      retire(1);
      dbg_addr = 3'd4; #1;
      n_chk++;
      if (dbg_data !== 16'hFFFE || flags[FLG_N] !== 1'b1) begin
         n_fail++; $display("FAIL sub_result: r4=%h N=%b, required FFFE/1", dbg_data, flags[FLG_N]);
      end
   endtask

   task automatic test_carry_zero();
      send(li(OP_LDI, 3'd5, 8'hFF));
      send(li(OP_LUI, 3'd5, 8'hFF));
      dbg_addr = 3'd5; #1;
      n_chk++;
      if (dbg_data !== 16'hFFFF) begin n_fail++; $display("FAIL lui_r5: got %h, required FFFF", dbg_data); end
      send(li(OP_LDI, 3'd6, 8'h01));
      send(rr(OP_ADD, 3'd7, 3'd5, 3'd6));
      retire(0);
      dbg_addr = 3'd7; #1;
      n_chk++;
      if (dbg_data !== 16'h0000 || flags !== 4'b1001) begin
         n_fail++; $display("FAIL carry_zero: r7=%h flags=%b, required 0000/1001", dbg_data, flags);
      end
   endtask

   task automatic test_ops();
      logic [3:0] ops[8];
      ops = '{OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_NOT, OP_ADD, OP_SUB};
      send(li(OP_LDI, 3'd0, 8'hAB));
      send(li(OP_LUI, 3'd0, 8'hCD));
      send(16'h0000);
      dbg_addr = 3'd0; #1;
      n_chk++;
      if (dbg_data !== 16'hCDAB || flags !== mflags) begin
         n_fail++; $display("FAIL r0_nop: r0=%h flags=%b, required CDAB/%b", dbg_data, flags, mflags);
      end
      for (int i = 1; i < 8; i++) begin
         send(li(OP_LDI, 3'(i), 8'($urandom)));
         send(li(OP_LUI, 3'(i), 8'($urandom)));
      end
      for (int k = 0; k < 16; k++) begin
         send(rr(ops[k % 8], 3'($urandom), 3'($urandom), 3'($urandom)));
         retire(0);
      end
      send(rr(OP_ADD, 3'd3, 3'd3, 3'd3));
      retire(0);
      send(rr(OP_SUB, 3'd3, 3'd2, 3'd3));
      retire(0);
   endtask

   task automatic test_illegal();
      logic [3:0] f0;
      f0 = mflags;
      send(16'hA000);
      n_chk++;
      if (illegal !== 1'b1 || instr_ready !== 1'b1) begin
         n_fail++; $display("FAIL illegal_pulse1: illegal=%b ready=%b, required 1/1", illegal, instr_ready);
      end
      send(16'hE1FF);
      n_chk++;
      if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse2: got %b, required 1", illegal); end
      tick();
      n_chk++;
      if (illegal !== 1'b0 || flags !== f0) begin
         n_fail++; $display("FAIL illegal_end: illegal=%b flags=%b, required 0/%b", illegal, flags, f0);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         n_chk++;
         if (dbg_data !== mreg[i]) begin n_fail++; $display("FAIL illegal_regs r%0d: got %h, required %h", i, dbg_data, mreg[i]); end
      end
   endtask

   task automatic test_abort();
      int lo;
      logic [19:0] r;
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      model_reset();
      send(li(OP_LDI, 3'd1, 8'h05));
      send(li(OP_LDI, 3'd2, 8'h03));
      send(rr(OP_ADD, 3'd3, 3'd1, 3'd2));
      rst_n = 1'b0; #2;
      model_reset();
      tick(); rst_n = 1'b1; tick();
      dbg_addr = 3'd3; #1;
      n_chk++;
      if (dbg_data !== 16'h0000 || flags !== 4'h0 || instr_ready !== 1'b1 || alu_op !== 4'h0) begin
         n_fail++; $display("FAIL abort: r3=%h flags=%b ready=%b op=%h, required 0000/0000/1/0", dbg_data, flags, instr_ready, alu_op);
      end
      send(li(OP_LDI, 3'd1, 8'h05));
      send(li(OP_LDI, 3'd2, 8'h03));
      // Held valid on an accumulating op: a second accept would leave r1 = 0x000B.
      instr = rr(OP_ADD, 3'd1, 3'd1, 3'd2); instr_valid = 1'b1;
      tick();
      r = alu_f(OP_ADD, mreg[1], mreg[2]); mreg[1] = r[15:0]; mflags = r[19:16];
      lo = 0;
      while (!instr_ready && lo < 10) begin tick(); lo++; end
      instr_valid = 1'b0;
      n_chk++;
      if (lo != 2) begin n_fail++; $display("FAIL held_ready_low: got %0d, required 2", lo); end
      tick();
      dbg_addr = 3'd1; #1;
      n_chk++;
      if (instr_ready !== 1'b1 || alu_op !== 4'h0 || dbg_data !== 16'h0008 || flags !== mflags) begin
         n_fail++; $display("FAIL held_once: ready=%b op=%h r1=%h flags=%b, required 1/0/0008/%b", instr_ready, alu_op, dbg_data, flags, mflags);
      end
   endtask

   initial begin
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_add();
      test_sub();
      test_carry_zero();
      test_ops();
      test_illegal();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule
